// File: rtl/job_arbiter_pkg.sv
// Shared types and defaults for the job arbiter.
// State encodings and default sizing live here.
package job_arbiter_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_TIMEOUT = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_ACK   = 2'd3
   } state_e;

endpackage

// File: rtl/job_arbiter_if.sv
// Requester/core handshake bundle for the job arbiter.
// master drives requests and core_done; slave is the arbiter.
interface job_arbiter_if
   import job_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ
);

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] ack;
   logic [NUM_REQ-1:0] grant;
   logic               ack_err;
   logic               core_start;
   logic               core_done;
   logic               busy;
   logic               timeout_err;

   modport master (
      output req,
      output core_done,
      input  ack,
      input  ack_err,
      input  grant,
      input  core_start,
      input  busy,
      input  timeout_err
   );

   modport slave (
      input  req,
      input  core_done,
      output ack,
      output ack_err,
      output grant,
      output core_start,
      output busy,
      output timeout_err
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches from last+1 upward with wrap; first set bit wins.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last,
   output logic [NUM_REQ-1:0] win_oh,
   output logic [IW-1:0]      win_idx,
   output logic               valid
);

   always_comb begin
      logic [IW-1:0] pos;
      win_oh  = '0;
      win_idx = '0;
      valid   = 1'b0;
      pos     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         pos = IW'((int'(last) + k) % NUM_REQ);
         if (!valid && req[pos]) begin
            valid       = 1'b1;
            win_idx     = pos;
            win_oh[pos] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/job_arbiter.sv
// Round-robin arbiter sharing one start/done core among NUM_REQ
// requesters, with a per-job timeout and sticky error flag.
module job_arbiter
   import job_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic          clk,
   input  logic          rst,
   job_arbiter_if.slave  bus
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
   // Last WAIT cycle: the increment taken here lands on TIMEOUT-1.
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 2);

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic               ack_err_q, ack_err_d;
   logic               start_q, start_d;
   logic               terr_q, terr_d;
   logic               abort_q, abort_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic [IW-1:0]      last_q, last_d;
   logic [IW-1:0]      win_q, win_d;

   logic [NUM_REQ-1:0] pick_oh;
   logic [IW-1:0]      pick_idx;
   logic               pick_valid;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_pick (
      .req     (bus.req),
      .last    (last_q),
      .win_oh  (pick_oh),
      .win_idx (pick_idx),
      .valid   (pick_valid)
   );

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ack_d     = '0;
      ack_err_d = 1'b0;
      start_d   = 1'b0;
      terr_d    = terr_q;
      abort_d   = abort_q;
      timer_d   = timer_q;
      last_d    = last_q;
      win_d     = win_q;
      unique case (state_q)
         S_IDLE: begin
            if (pick_valid) begin
               grant_d = pick_oh;
               win_d   = pick_idx;
               start_d = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Completion beats the timeout on the same cycle.
            if (bus.core_done) begin
               ack_d   = grant_q;
               state_d = S_ACK;
            end else if (timer_q == T_LAST) begin
               timer_d   = timer_q + TW'(1);
               abort_d   = 1'b1;
               terr_d    = 1'b1;
               ack_d     = grant_q;
               ack_err_d = 1'b1;
               state_d   = S_ACK;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_ACK: begin
            last_d  = win_q;
            grant_d = '0;
            abort_d = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         ack_q     <= '0;
         ack_err_q <= 1'b0;
         start_q   <= 1'b0;
         terr_q    <= 1'b0;
         abort_q   <= 1'b0;
         timer_q   <= '0;
         last_q    <= LAST_RST;
         win_q     <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ack_q     <= ack_d;
         ack_err_q <= ack_err_d;
         start_q   <= start_d;
         terr_q    <= terr_d;
         abort_q   <= abort_d;
         timer_q   <= timer_d;
         last_q    <= last_d;
         win_q     <= win_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.ack         = ack_q;
   assign bus.ack_err     = ack_err_q;
   assign bus.core_start  = start_q;
   assign bus.timeout_err = terr_q;
   assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_job_arbiter.sv
// Bench for job_arbiter: acks are scored against a queue of
// expected {requester, error} pairs pushed as jobs are launched.
module tb_job_arbiter;

   localparam int N  = 4;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   job_arbiter_if #(.NUM_REQ(N)) bus();

   job_arbiter #(
      .NUM_REQ (N),
      .TIMEOUT (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [N-1:0] who;
      logic         err;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_chk  = 0;
   int   n_pass = 0;

   logic [N-1:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start();
      int n;
      n = 0;
      while (!bus.core_start && n < 40) begin
         step();
         n++;
      end
      chk("start_seen", bus.core_start, 1);
   endtask

   task automatic push(input logic [N-1:0] who, input logic err);
      exp_t e;
      e.who = who;
      e.err = err;
      sb_q.push_back(e);
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_grant"}, bus.grant, 0);
      chk({tag, "_ack"}, bus.ack, 0);
      chk({tag, "_ack_err"}, bus.ack_err, 0);
      chk({tag, "_start"}, bus.core_start, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_terr"}, bus.timeout_err, 0);
   endtask

   always @(negedge clk) begin
      if (!rst && bus.ack != '0) begin
         if (sb_q.size() == 0) begin
            chk("ack_unexpected", bus.ack, 0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("sb_ack", bus.ack, mon_e.who);
            chk("sb_ack_err", bus.ack_err, mon_e.err);
         end
      end
   end

   initial begin
      bus.req       = '0;
      bus.core_done = 1'b0;
      rst           = 1'b1;
      step();
      step();
      check_reset_outs("rst");
      rst = 1'b0;
      step();

      // single request
      bus.req = 4'b0001;
      push(4'b0001, 1'b0);
      step();
      chk("s_grant", bus.grant, 4'b0001);
      chk("s_start", bus.core_start, 1);
      chk("s_busy", bus.busy, 1);
      step();
      chk("s_start_pulse", bus.core_start, 0);
      step();
      bus.core_done = 1'b1;
      step();
      bus.core_done = 1'b0;
      chk("s_ack", bus.ack, 4'b0001);
      chk("s_ack_err", bus.ack_err, 0);
      bus.req = '0;
      step();
      chk("s_busy_low", bus.busy, 0);
      chk("s_grant_clr", bus.grant, 0);

      // fresh reset so fairness starts from index 0
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      bus.req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_start();
         chk("rr_grant", bus.grant, rr_exp[i]);
         push(rr_exp[i], 1'b0);
         step();
         step();
         bus.core_done = 1'b1;
         step();
         bus.core_done = 1'b0;
         if (i == 4) bus.req = '0;
         chk("rr_ack", bus.ack, rr_exp[i]);
      end
      step();

      // done on the timeout boundary cycle
      bus.req = 4'b0010;
      wait_start();
      chk("b_grant", bus.grant, 4'b0010);
      push(4'b0010, 1'b0);
      repeat (7) step();
      chk("b_no_early_ack", bus.ack, 0);
      bus.core_done = 1'b1;
      step();
      bus.core_done = 1'b0;
      chk("b_ack", bus.ack, 4'b0010);
      chk("b_ack_err", bus.ack_err, 0);
      chk("b_terr", bus.timeout_err, 0);
      bus.req = '0;
      step();

      // timeout
      bus.req = 4'b0100;
      wait_start();
      chk("t_grant", bus.grant, 4'b0100);
      push(4'b0100, 1'b1);
      repeat (7) step();
      chk("t_no_early_ack", bus.ack, 0);
      chk("t_busy", bus.busy, 1);
      step();
      chk("t_ack", bus.ack, 4'b0100);
      chk("t_ack_err", bus.ack_err, 1);
      chk("t_terr", bus.timeout_err, 1);
      bus.req = '0;
      step();
      chk("t_idle", bus.busy, 0);
      step();
      step();
      chk("t_terr_sticky", bus.timeout_err, 1);

      // spurious done in IDLE and START
      bus.core_done = 1'b1;
      step();
      chk("sp_idle_busy", bus.busy, 0);
      chk("sp_idle_ack", bus.ack, 0);
      bus.req = 4'b0001;
      push(4'b0001, 1'b0);
      step();
      chk("sp_start", bus.core_start, 1);
      chk("sp_grant", bus.grant, 4'b0001);
      step();
      bus.core_done = 1'b0;
      chk("sp_wait_ack", bus.ack, 0);
      chk("sp_wait_busy", bus.busy, 1);
      step();
      chk("sp_wait2_ack", bus.ack, 0);
      bus.core_done = 1'b1;
      step();
      bus.core_done = 1'b0;
      chk("sp_ack", bus.ack, 4'b0001);
      bus.req = '0;
      step();

      // reset mid-WAIT
      bus.req = 4'b1000;
      wait_start();
      chk("r_grant", bus.grant, 4'b1000);
      step();
      step();
      chk("r_in_wait", bus.busy, 1);
      #2 rst = 1'b1;
      #1;
      check_reset_outs("r_async");
      bus.req = '0;
      step();
      step();
      rst = 1'b0;
      bus.req = 4'b1010;
      push(4'b0010, 1'b0);
      wait_start();
      chk("r_first", bus.grant, 4'b0010);
      step();
      bus.core_done = 1'b1;
      step();
      bus.core_done = 1'b0;
      chk("r_ack1", bus.ack, 4'b0010);
      bus.req = 4'b1000;
      push(4'b1000, 1'b0);
      wait_start();
      chk("r_second", bus.grant, 4'b1000);
      step();
      bus.core_done = 1'b1;
      step();
      bus.core_done = 1'b0;
      chk("r_ack2", bus.ack, 4'b1000);
      bus.req = '0;
      step();
      step();

      chk("sb_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
